// File: rtl/lc3_pkg.sv
// Shared LC-3 types: ISA opcodes, core FSM states, ALU operations and
// the immediate/offset extension helpers used by the decoder.
package lc3_pkg;

  localparam logic [15:0] LC3_PC_RESET = 16'h3000;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_IND    = 3'd3,
    ST_MEMRD  = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_AND  = 2'd1,
    ALU_NOT  = 2'd2,
    ALU_PASS = 2'd3
  } alu_op_e;

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  function automatic logic [15:0] sext11(input logic [10:0] v);
    return {{5{v[10]}}, v};
  endfunction

  function automatic logic [15:0] zext8(input logic [7:0] v);
    return {8'h00, v};
  endfunction

endpackage

// File: rtl/lc3_if.sv
// Single read/write port between the LC-3 core (master) and unified memory (slave).
interface lc3_if #(
  parameter int ADDRESS_WIDTH = 16
);
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_rd;
  logic                     mem_we;
  logic [15:0]              mem_wdata;
  logic [15:0]              mem_rdata;

  modport master (
    output mem_addr, mem_rd, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_rd, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lc3_alu.sv
// Combinational LC-3 ALU: ADD/AND/NOT/PASS on 16-bit operands plus the
// one-hot N/Z/P condition code of the result.
module lc3_alu
  import lc3_pkg::*;
(
  input  alu_op_e     op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y,
  output logic [2:0]  nzp
);

  logic signed [15:0] sa;
  logic signed [15:0] sb;

  assign sa = a;
  assign sb = b;

  always_comb begin
    y = a;
    unique case (op)
      ALU_ADD:  y = 16'(sa + sb);
      ALU_AND:  y = a & b;
      ALU_NOT:  y = ~a;
      default:  y = a;
    endcase
  end

  assign nzp = {y[15], (y == 16'h0000), (!y[15] && (y != 16'h0000))};

endmodule

// File: rtl/lc3_core.sv
// Multicycle LC-3 core: FETCH/DECODE/EXEC FSM with IND/MEMRD for memory operands.
// Build option LC3_TRAP_EN: TRAP vectors through mem[trapvect8]; otherwise TRAP halts the core.
module lc3_core
  import lc3_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = 16,
  parameter logic [15:0] PC_RESET      = LC3_PC_RESET
) (
  input  logic  clk,
  input  logic  reset,
  lc3_if.master mem,
  output logic  halted
);

  state_e      state;
  state_e      state_nx;
  logic [15:0] pc;
  logic [15:0] pc_nx;
  logic [15:0] ir;
  logic [2:0]  nzp;
  logic [15:0] regs [8];

  opcode_e     opcode;
  logic [15:0] sr1_val;
  logic [15:0] sr2_val;
  logic [15:0] dr_val;
  logic [15:0] off9;
  logic [15:0] off6;

  logic        ir_we;
  logic        rf_we;
  logic        nzp_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;

  alu_op_e     alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_y;
  logic [2:0]  alu_nzp;

  logic        bus_rd;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;

  assign opcode  = opcode_e'(ir[15:12]);
  assign sr1_val = regs[ir[8:6]];
  assign sr2_val = regs[ir[2:0]];
  assign dr_val  = regs[ir[11:9]];
  assign off9    = sext9(ir[8:0]);
  assign off6    = sext6(ir[5:0]);

  lc3_alu u_alu (
    .op  (alu_op),
    .a   (alu_a),
    .b   (alu_b),
    .y   (alu_y),
    .nzp (alu_nzp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    nzp_we    = 1'b0;
    rf_waddr  = ir[11:9];
    rf_wdata  = alu_y;
    alu_op    = ALU_PASS;
    alu_a     = sr1_val;
    alu_b     = ir[5] ? sext5(ir[4:0]) : sr2_val;
    bus_rd    = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 16'h0000;
    bus_wdata = 16'h0000;
    unique case (state)
      ST_FETCH: begin
        bus_rd   = 1'b1;
        bus_addr = pc;
        pc_nx    = pc + 16'd1;
        state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        ir_we    = 1'b1;
        state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        state_nx = ST_FETCH;
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: begin
            alu_op = (opcode == OP_ADD) ? ALU_ADD :
                     (opcode == OP_AND) ? ALU_AND : ALU_NOT;
            rf_we  = 1'b1;
            nzp_we = 1'b1;
          end
          OP_BR: begin
            if ((ir[11:9] & nzp) != 3'b000) pc_nx = pc + off9;
          end
          OP_JMP: pc_nx = sr1_val;
          OP_JSR: begin
            // Both writes use pre-instruction values, so JSRR R7 jumps to the old R7.
            rf_we    = 1'b1;
            rf_waddr = 3'd7;
            rf_wdata = pc;
            pc_nx    = ir[11] ? (pc + sext11(ir[10:0])) : sr1_val;
          end
          OP_LEA: begin
            rf_we    = 1'b1;
            rf_wdata = pc + off9;
          end
          OP_LD, OP_LDR: begin
            bus_rd   = 1'b1;
            bus_addr = (opcode == OP_LD) ? (pc + off9) : (sr1_val + off6);
            state_nx = ST_MEMRD;
          end
          OP_LDI, OP_STI: begin
            bus_rd   = 1'b1;
            bus_addr = pc + off9;
            state_nx = ST_IND;
          end
          OP_ST, OP_STR: begin
            bus_we    = 1'b1;
            bus_addr  = (opcode == OP_ST) ? (pc + off9) : (sr1_val + off6);
            bus_wdata = dr_val;
          end
`ifdef LC3_TRAP_EN
          OP_TRAP: begin
            rf_we    = 1'b1;
            rf_waddr = 3'd7;
            rf_wdata = pc;
            bus_rd   = 1'b1;
            bus_addr = zext8(ir[7:0]);
            state_nx = ST_IND;
          end
`else
          OP_TRAP: state_nx = ST_HALT;
`endif
          default: ;
        endcase
      end
      ST_IND: begin
        state_nx = ST_FETCH;
        case (opcode)
          OP_LDI: begin
            bus_rd   = 1'b1;
            bus_addr = mem.mem_rdata;
            state_nx = ST_MEMRD;
          end
          OP_STI: begin
            bus_we    = 1'b1;
            bus_addr  = mem.mem_rdata;
            bus_wdata = dr_val;
          end
`ifdef LC3_TRAP_EN
          OP_TRAP: pc_nx = mem.mem_rdata;
`endif
          default: ;
        endcase
      end
      ST_MEMRD: begin
        alu_op   = ALU_PASS;
        alu_a    = mem.mem_rdata;
        rf_we    = 1'b1;
        nzp_we   = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= PC_RESET;
      ir  <= 16'h0000;
      nzp <= 3'b010;
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
    end else begin
      pc <= pc_nx;
      if (ir_we)  ir             <= mem.mem_rdata;
      if (nzp_we) nzp            <= alu_nzp;
      if (rf_we)  regs[rf_waddr] <= rf_wdata;
    end
  end

  // Reset holds FSM in FETCH, so the bus is forced quiet while reset is low.
  assign mem.mem_rd    = bus_rd & reset;
  assign mem.mem_we    = bus_we & reset;
  assign mem.mem_addr  = reset ? bus_addr[ADDRESS_WIDTH-1:0] : '0;
  assign mem.mem_wdata = reset ? bus_wdata : 16'h0000;
  assign halted        = reset & (state == ST_HALT);

endmodule

// File: tb/tb_lc3_core.sv
// Bench for lc3_core: ISA-level reference model predicts the per-cycle bus trace
// for directed programs and random instruction streams.
module tb_lc3_core;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic halted;

  lc3_if #(.ADDRESS_WIDTH(16)) bus ();

  lc3_core #(.ADDRESS_WIDTH(16), .PC_RESET(16'h3000)) dut (
    .clk    (clk),
    .reset  (reset),
    .mem    (bus),
    .halted (halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem  [0:65535] = '{default: 16'h0000};
  logic [15:0] mmem [0:65535] = '{default: 16'h0000};
  logic        poke_en   = 1'b0;
  logic [15:0] poke_addr = 16'h0000;
  logic [15:0] poke_data = 16'h0000;

  always @(posedge clk) begin
    if (poke_en)         mem[poke_addr]    = poke_data;
    else if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  typedef struct packed {
    logic        rd;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        halt;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] mr [8];
  logic [15:0] mpc;
  logic [2:0]  mnzp;
  logic        mhalt;
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
    logic [15:0] r = v;
    for (int i = bits; i < 16; i++) r[i] = v[bits-1];
    return r;
  endfunction

  function automatic void push(input logic rd, input logic we, input logic [15:0] a,
                               input logic [15:0] d, input logic h);
    ev_t e;
    e.rd = rd; e.we = we; e.addr = a; e.wdata = d; e.halt = h;
    exp_q.push_back(e);
  endfunction

  function automatic void wr(input logic [2:0] r, input logic [15:0] v);
    mr[r] = v;
    mnzp  = v[15] ? 3'b100 : (v == 16'h0000) ? 3'b010 : 3'b001;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) mr[i] = 16'h0000;
    mpc   = 16'h3000;
    mnzp  = 3'b010;
    mhalt = 1'b0;
    exp_q.delete();
  endfunction

  // Executes one instruction and queues the bus activity of every cycle it takes.
  function automatic void model_step();
    logic [15:0] ins, src2, ea, ptr, t;
    logic [2:0]  dr, sr1;
    if (mhalt) begin
      push(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      return;
    end
    ins = mmem[mpc];
    push(1'b1, 1'b0, mpc, 16'h0, 1'b0);
    mpc = mpc + 16'd1;
    push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    dr   = ins[11:9];
    sr1  = ins[8:6];
    src2 = ins[5] ? sx(ins, 5) : mr[ins[2:0]];
    case (ins[15:12])
      4'h1: begin wr(dr, mr[sr1] + src2); push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0); end
      4'h5: begin wr(dr, mr[sr1] & src2); push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0); end
      4'h9: begin wr(dr, ~mr[sr1]);       push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0); end
      4'h0: begin
        if ((ins[11:9] & mnzp) != 3'b000) mpc = mpc + sx(ins, 9);
        push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      end
      4'hC: begin mpc = mr[sr1]; push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0); end
      4'h4: begin
        t     = ins[11] ? mpc + sx(ins, 11) : mr[sr1];
        mr[7] = mpc;
        mpc   = t;
        push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      end
      4'hE: begin mr[dr] = mpc + sx(ins, 9); push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0); end
      4'h2, 4'h6: begin
        ea = (ins[15:12] == 4'h2) ? mpc + sx(ins, 9) : mr[sr1] + sx(ins, 6);
        push(1'b1, 1'b0, ea, 16'h0, 1'b0);
        wr(dr, mmem[ea]);
        push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      end
      4'hA: begin
        ea  = mpc + sx(ins, 9);
        ptr = mmem[ea];
        push(1'b1, 1'b0, ea, 16'h0, 1'b0);
        push(1'b1, 1'b0, ptr, 16'h0, 1'b0);
        wr(dr, mmem[ptr]);
        push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      end
      4'h3, 4'h7: begin
        ea = (ins[15:12] == 4'h3) ? mpc + sx(ins, 9) : mr[sr1] + sx(ins, 6);
        push(1'b0, 1'b1, ea, mr[dr], 1'b0);
        mmem[ea] = mr[dr];
      end
      4'hB: begin
        ea  = mpc + sx(ins, 9);
        ptr = mmem[ea];
        push(1'b1, 1'b0, ea, 16'h0, 1'b0);
        push(1'b0, 1'b1, ptr, mr[dr], 1'b0);
        mmem[ptr] = mr[dr];
      end
      4'hF: begin
`ifdef LC3_TRAP_EN
        push(1'b1, 1'b0, {8'h00, ins[7:0]}, 16'h0, 1'b0);
        mr[7] = mpc;
        mpc   = mmem[{8'h00, ins[7:0]}];
        push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
`else
        push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        mhalt = 1'b1;
`endif
      end
      default: push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    mmem[a]   = d;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic start_test();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    check("rst_mem_rd", bus.mem_rd, 16'h0);
    check("rst_mem_we", bus.mem_we, 16'h0);
    check("rst_halted", halted, 16'h0);
    check("rst_mem_addr", bus.mem_addr, 16'h0);
    check("rst_mem_wdata", bus.mem_wdata, 16'h0);
    reset = 1'b1;
  endtask

  task automatic one_cycle();
    ev_t e;
    if (exp_q.size() == 0) model_step();
    e = exp_q.pop_front();
    #1;
    check("mem_rd", bus.mem_rd, e.rd);
    check("mem_we", bus.mem_we, e.we);
    check("halted", halted, e.halt);
    if (e.rd || e.we) check("mem_addr", bus.mem_addr, e.addr);
    if (e.we) check("mem_wdata", bus.mem_wdata, e.wdata);
    @(negedge clk);
    #1;
  endtask

  task automatic run_instr(input int n);
    for (int k = 0; k < n; k++) begin
      model_step();
      while (exp_q.size() != 0) one_cycle();
    end
  endtask

  initial begin
    logic [15:0] w;

    // ADD R1,R0,#5 ; ADD R1,R1,#1 ; BRp +1 ; (skipped ADD) ; ST R1 -> x3006
    start_test();
    poke(16'h3000, 16'h1225); poke(16'h3001, 16'h1261); poke(16'h3002, 16'h0201);
    poke(16'h3003, 16'h1261); poke(16'h3004, 16'h3201); poke(16'h3006, 16'hFFFF);
    release_reset();
    run_instr(4);
    check("add_result", mem[16'h3006], 16'h0006);

    // AND R2,R2,#0 ; BRz +1 ; (skipped ADD) ; ST R1,+2 -> x3006
    start_test();
    poke(16'h3000, 16'h54A0); poke(16'h3001, 16'h0401); poke(16'h3002, 16'h1261);
    poke(16'h3003, 16'h3202); poke(16'h3006, 16'hFFFF);
    release_reset();
    run_instr(3);
    check("brz_st", mem[16'h3006], 16'h0000);

    // LDI R1 via x3002 -> x4000 = x8000 ; BRn +2 ; ST R1 -> x3010
    start_test();
    poke(16'h3000, 16'hA201); poke(16'h3001, 16'h0802); poke(16'h3002, 16'h4000);
    poke(16'h3003, 16'h0000); poke(16'h3004, 16'h320B); poke(16'h4000, 16'h8000);
    poke(16'h3010, 16'h0000);
    release_reset();
    run_instr(3);
    check("ldi_result", mem[16'h3010], 16'h8000);

    // TRAP x25, then ST R7 at the vector target
    start_test();
    poke(16'h3000, 16'hF025); poke(16'h0025, 16'h0520);
    poke(16'h0520, 16'h3E01); poke(16'h0522, 16'h0000);
    release_reset();
`ifdef LC3_TRAP_EN
    run_instr(2);
    check("trap_r7", mem[16'h0522], 16'h3001);
`else
    run_instr(5);
    check("trap_halted", halted, 16'h1);
`endif

    // PC wrap: ADD R2,R0,#-1 ; JMP R2 ; xFFFF: ADD R3,R0,#7 ; x0000: ST R3 -> x0002
    start_test();
    poke(16'h3000, 16'h14BF); poke(16'h3001, 16'hC080); poke(16'hFFFF, 16'h1627);
    poke(16'h0000, 16'h3601); poke(16'h0001, 16'h0000); poke(16'h0002, 16'h0000);
    release_reset();
    run_instr(4);
    check("pc_wrap", mem[16'h0002], 16'h0007);

    // Reset during MEMRD of an LD aborts it; core restarts at x3000
    start_test();
    poke(16'h3000, 16'h1225); poke(16'h3001, 16'h2202); poke(16'h3002, 16'h3202);
    poke(16'h3003, 16'h0000); poke(16'h3004, 16'h1234); poke(16'h3005, 16'h0000);
    release_reset();
    for (int c = 0; c < 6; c++) one_cycle();
    reset = 1'b0;
    #1;
    check("abort_mem_rd", bus.mem_rd, 16'h0);
    check("abort_mem_we", bus.mem_we, 16'h0);
    start_test();
    release_reset();
    #1;
    check("abort_refetch", bus.mem_addr, 16'h3000);
    #1;
    run_instr(3);
    check("abort_ld_st", mem[16'h3005], 16'h1234);

    // Random instruction streams (TRAP replaced so the core keeps running)
    for (int s = 0; s < 3; s++) begin
      start_test();
      for (int i = 0; i < 80; i++) begin
        w = 16'($urandom);
        if (w[15:12] == 4'hF) w[15:12] = 4'h1;
        poke(16'h3000 + 16'(i), w);
      end
      release_reset();
      run_instr(150);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
